// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader.
// Takes a stream of instruction words over a valid/ready handshake and
// writes them to consecutive word addresses of the core's instruction
// memory. The core is held in reset during the load and for a short
// hold period afterwards, and is then released.
module imem_loader #(
    parameter int ADDR_W    = 32,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0,
    parameter int ADDR_STEP = 4,
    parameter int RST_HOLD  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       len,
    input  logic              s_valid,
    input  logic [31:0]       s_data,
    output logic              s_ready,
    output logic              instwen,
    output logic [ADDR_W-1:0] addwrite,
    output logic [31:0]       instrdatain,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        HOLD,
        RUN
    } state_t;

    // Lengths are compared one bit wider so that DEPTH itself is representable.
    localparam logic [16:0]       DEPTH_L   = 17'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_L    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STEP_L    = ADDR_W'(ADDR_STEP);
    // Last value of the hold counter before the core is released.
    localparam logic [15:0]       HOLD_LAST = 16'(RST_HOLD - 1);

    state_t              state_q, state_d;
    logic [15:0]         remaining_q, remaining_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         holdCnt_q, holdCnt_d;
    logic                instwen_q, instwen_d;
    logic [ADDR_W-1:0]   addwrite_q, addwrite_d;
    logic [31:0]         data_q, data_d;
    logic                cpuReset_q, cpuReset_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;

    logic                lenLegal;
    logic                accept;

    // Ready depends only on the loader's own state, never on s_valid.
    assign s_ready  = (state_q == LOAD) && (remaining_q != 16'd0);
    assign accept   = s_valid && s_ready;
    assign lenLegal = (len != 16'd0) && ({1'b0, len} <= DEPTH_L);

    assign instwen     = instwen_q;
    assign addwrite    = addwrite_q;
    assign instrdatain = data_q;
    assign cpu_reset   = cpuReset_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;

    // Next-state and registered-output logic; every write pulse lasts one cycle.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        holdCnt_d   = holdCnt_q;
        instwen_d   = 1'b0;
        addwrite_d  = addwrite_q;
        data_d      = data_q;
        cpuReset_d  = cpuReset_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;

        case (state_q)
            IDLE, RUN: begin
                if (start) begin
                    if (lenLegal) begin
                        state_d     = LOAD;
                        remaining_d = len;
                        addr_d      = BASE_L;
                        busy_d      = 1'b1;
                        error_d     = 1'b0;
                        done_d      = 1'b0;
                        cpuReset_d  = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    instwen_d   = 1'b1;
                    addwrite_d  = addr_q;
                    data_d      = s_data;
                    addr_d      = addr_q + STEP_L;
                    remaining_d = remaining_q - 16'd1;
                    if (remaining_q == 16'd1) begin
                        state_d   = HOLD;
                        holdCnt_d = 16'd0;
                    end
                end
            end
            HOLD: begin
                if (holdCnt_q == HOLD_LAST) begin
                    state_d    = RUN;
                    cpuReset_d = 1'b0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                end else begin
                    holdCnt_d = holdCnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            remaining_q <= 16'd0;
            addr_q      <= '0;
            holdCnt_q   <= 16'd0;
            instwen_q   <= 1'b0;
            addwrite_q  <= '0;
            data_q      <= 32'd0;
            cpuReset_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            holdCnt_q   <= holdCnt_d;
            instwen_q   <= instwen_d;
            addwrite_q  <= addwrite_d;
            data_q      <= data_d;
            cpuReset_q  <= cpuReset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed loads, a table of start lengths,
// and randomized loads with random gaps, noise and mid-load resets.
module tb_imem_loader;

    localparam int          RST_HOLD  = 2;
    localparam logic [31:0] BASE_ADDR = 32'h0;
    localparam logic [31:0] ADDR_STEP = 32'h4;

    typedef struct {
        logic [15:0] len;
        logic        expError;
    } startVec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] len;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic        instwen;
    logic [31:0] addwrite;
    logic [31:0] instrdatain;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;

    int passCount  = 0;
    int checkCount = 0;

    // Expected view of the world: held write-port values, whether the core
    // is running, and the sticky error flag.
    logic [31:0] lastAddr;
    logic [31:0] lastData;
    logic        inRun;
    logic        errModel;
    logic [31:0] wordQ[$];

    // Free-running clock.
    always #5 clk = ~clk;

    imem_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .len        (len),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .instwen    (instwen),
        .addwrite   (addwrite),
        .instrdatain(instrdatain),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    // Absolute time limit so the bench can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    endtask

    task automatic applyStimulus(input logic st, input logic [15:0] ln, input logic v, input logic [31:0] d);
        start   = st;
        len     = ln;
        s_valid = v;
        s_data  = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fillWords(input int n);
        wordQ.delete();
        for (int i = 0; i < n; i++) wordQ.push_back($urandom);
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_instwen"}, instwen, 0);
        checkOutput({tag, "_ready"}, s_ready, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, inRun);
        checkOutput({tag, "_cpuReset"}, cpu_reset, !inRun);
        checkOutput({tag, "_error"}, error, errModel);
        checkOutput({tag, "_addr"}, addwrite, lastAddr);
        checkOutput({tag, "_data"}, instrdatain, lastData);
    endtask

    task automatic doReset(input int n);
        reset = 1'b0;
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'($urandom), 16'($urandom), 1'($urandom), $urandom);
            tick();
            checkOutput("rst_instwen", instwen, 0);
            checkOutput("rst_addr", addwrite, 0);
            checkOutput("rst_data", instrdatain, 0);
            checkOutput("rst_cpuReset", cpu_reset, 1);
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_done", done, 0);
            checkOutput("rst_error", error, 0);
            checkOutput("rst_ready", s_ready, 0);
        end
        reset = 1'b1;
        applyStimulus(1'b0, 16'd0, 1'b0, 32'd0);
        lastAddr = 32'd0;
        lastData = 32'd0;
        inRun    = 1'b0;
        errModel = 1'b0;
    endtask

    task automatic illegalStart(input logic [15:0] ln);
        applyStimulus(1'b1, ln, 1'b1, $urandom);
        tick();
        applyStimulus(1'b0, 16'd0, 1'b1, $urandom);
        errModel = 1'b1;
        checkQuiet("illegal");
        tick();
        applyStimulus(1'b0, 16'd0, 1'b0, 32'd0);
        checkQuiet("illegalSticky");
    endtask

    // Runs one load of wordQ[0..n-1]. Words are offered after fixedGap idle
    // cycles (or a random gap); noise drives stray start pulses. If abortAfter
    // words have been written the task returns with the load still open.
    task automatic runLoad(input int n, input int fixedGap, input bit randomGap,
                           input int abortAfter, input bit noise);
        int          sent     = 0;
        int          lowLeft  = 0;
        int          guard    = 0;
        logic [31:0] addrModel = BASE_ADDR;
        logic        v;
        applyStimulus(1'b1, 16'(n), 1'b0, 32'd0);
        tick();
        errModel = 1'b0;
        inRun    = 1'b0;
        checkOutput("start_busy", busy, 1);
        checkOutput("start_cpuReset", cpu_reset, 1);
        checkOutput("start_done", done, 0);
        checkOutput("start_error", error, 0);
        checkOutput("start_instwen", instwen, 0);
        while (sent < n) begin
            guard++;
            if (guard > 5000) begin
                checkOutput("loadTimeout", 0, 1);
                break;
            end
            checkOutput("load_ready", s_ready, 1);
            if (lowLeft > 0) begin
                v = 1'b0;
                lowLeft--;
            end else begin
                v = 1'b1;
            end
            applyStimulus(noise ? 1'($urandom) : 1'b0, 16'($urandom), v, v ? wordQ[sent] : $urandom);
            tick();
            if (v) begin
                lastAddr = addrModel;
                lastData = wordQ[sent];
                checkOutput("write_instwen", instwen, 1);
                checkOutput("write_addr", addwrite, lastAddr);
                checkOutput("write_data", instrdatain, lastData);
                addrModel = addrModel + ADDR_STEP;
                sent++;
                lowLeft = randomGap ? $urandom_range(0, 3) : fixedGap;
            end else begin
                checkOutput("gap_instwen", instwen, 0);
                checkOutput("gap_addr", addwrite, lastAddr);
                checkOutput("gap_data", instrdatain, lastData);
            end
            checkOutput("load_cpuReset", cpu_reset, 1);
            checkOutput("load_busy", busy, 1);
            checkOutput("load_done", done, 0);
            checkOutput("load_error", error, 0);
            if (sent == abortAfter) return;
        end
        for (int k = 1; k <= RST_HOLD; k++) begin
            checkOutput("hold_ready", s_ready, 0);
            applyStimulus(noise ? 1'($urandom) : 1'b0, 16'($urandom), 1'b1, $urandom);
            tick();
            checkOutput("hold_instwen", instwen, 0);
            checkOutput("hold_addr", addwrite, lastAddr);
            checkOutput("hold_data", instrdatain, lastData);
            checkOutput("hold_cpuReset", cpu_reset, (k < RST_HOLD) ? 1 : 0);
            checkOutput("hold_busy", busy, (k < RST_HOLD) ? 1 : 0);
            checkOutput("hold_done", done, (k == RST_HOLD) ? 1 : 0);
        end
        applyStimulus(1'b0, 16'd0, 1'b0, 32'd0);
        inRun = 1'b1;
        checkOutput("run_error", error, errModel);
        checkOutput("run_ready", s_ready, 0);
        tick();
        checkQuiet("run");
    endtask

    // Main test sequence.
    initial begin
        startVec_t vecs[6];
        vecs[0] = '{len: 16'd0,     expError: 1'b1};
        vecs[1] = '{len: 16'd257,   expError: 1'b1};
        vecs[2] = '{len: 16'd1,     expError: 1'b0};
        vecs[3] = '{len: 16'hFFFF,  expError: 1'b1};
        vecs[4] = '{len: 16'd256,   expError: 1'b0};
        vecs[5] = '{len: 16'd1000,  expError: 1'b1};

        reset = 1'b0;
        applyStimulus(1'b0, 16'd0, 1'b0, 32'd0);
        doReset(3);
        tick();
        checkQuiet("idle");

        $display("[TB] back-to-back load");
        wordQ = '{32'h20080005, 32'h20090007, 32'h01095020};
        runLoad(3, 0, 1'b0, -1, 1'b0);

        $display("[TB] reload from run");
        wordQ = '{32'hDEADBEEF};
        runLoad(1, 0, 1'b0, -1, 1'b0);

        $display("[TB] gapped valid");
        fillWords(4);
        runLoad(4, 2, 1'b0, -1, 1'b0);

        $display("[TB] start length table");
        doReset(1);
        foreach (vecs[i]) begin
            if (vecs[i].expError) begin
                illegalStart(vecs[i].len);
            end else begin
                fillWords(int'(vecs[i].len));
                runLoad(int'(vecs[i].len), 0, 1'b1, -1, 1'b0);
            end
        end

        $display("[TB] reset mid-load");
        fillWords(5);
        runLoad(5, 0, 1'b0, 2, 1'b0);
        doReset(1);
        fillWords(2);
        runLoad(2, 0, 1'b0, -1, 1'b0);

        $display("[TB] randomized loads");
        for (int it = 0; it < 30; it++) begin
            int n;
            if ($urandom_range(0, 4) == 0) begin
                illegalStart(($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(257, 65535)));
            end else begin
                n = $urandom_range(1, 12);
                fillWords(n);
                if ($urandom_range(0, 7) == 0) begin
                    runLoad(n, 0, 1'b1, $urandom_range(0, n - 1), 1'b1);
                    doReset($urandom_range(1, 2));
                end else begin
                    runLoad(n, 0, 1'b1, -1, 1'b1);
                end
            end
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time instruction-memory loader sitting directly upstream of the MIPS core's instruction-memory write port.
- Accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them to consecutive word addresses through instwen/addwrite/instrdatain.
- Holds the core in reset while loading, then releases it.
- Replaces ad-hoc testbench pokes of the instruction-memory port with a deterministic, checkable sequence.

Parameters:
ADDR_W, 32, width of addwrite.
DEPTH, 256, instruction-memory capacity in words; maximum legal load length.
BASE_ADDR, 0, byte address of the first word written.
ADDR_STEP, 4, byte increment between consecutive words.
RST_HOLD, 2, cycles the core reset stays asserted after the last write (minimum 1).

Ports:
clk  input  1  system clock, all logic on posedge.
reset  input  1  synchronous, active-low reset.
start  input  1  single-cycle request to begin a load.
len  input  16  number of words to load; sampled when start is accepted.
s_valid  input  1  upstream word valid.
s_data  input  32  upstream instruction word.
s_ready  output  1  loader accepts a word this cycle.
instwen  output  1  instruction-memory write enable.
addwrite  output  ADDR_W  instruction-memory write byte address.
instrdatain  output  32  instruction-memory write data.
cpu_reset  output  1  active-high reset to the core.
busy  output  1  load or hold in progress.
done  output  1  load complete, core running.
error  output  1  last start rejected (len==0 or len>DEPTH).

Behaviour:
- reset low at a clk edge forces the following, regardless of state (including mid-load): state=IDLE; instwen=0, addwrite=0, instrdatain=0, cpu_reset=1, busy=0, done=0, error=0; internal address and word counters cleared.
- s_ready is combinational: s_ready=1 exactly when state==LOAD and remaining>0. It does not depend on s_valid.
- All other outputs are registered.
- A word is accepted when s_valid && s_ready at a clk edge.
- States: IDLE, LOAD, HOLD, RUN.
- IDLE:
  - start && (len==0 || len>DEPTH): error=1 next cycle; stay IDLE.
  - start with a legal len: latch remaining=len, addr=BASE_ADDR; next cycle busy=1, error=0, done=0, cpu_reset=1; go to LOAD.
- LOAD:
  - On each accepted word, the next cycle drives instwen=1, addwrite=addr, instrdatain=s_data (1-cycle latency). Then addr+=ADDR_STEP (modulo 2^ADDR_W) and remaining-=1.
  - Cycles with no accepted word: instwen=0; addwrite and instrdatain hold their last values.
  - When the last word is accepted, go to HOLD. Its write pulse appears in the first HOLD cycle.
  - start is ignored in LOAD.
- HOLD:
  - cpu_reset=1, busy=1, s_ready=0.
  - A counter runs so that cpu_reset deasserts exactly RST_HOLD cycles after the cycle in which the last instwen was high.
  - Then go to RUN. start is ignored in HOLD.
- RUN:
  - cpu_reset=0, done=1, busy=0, instwen=0.
  - start with a legal len: reload exactly as from IDLE. cpu_reset reasserts and done clears on the next cycle.
  - start with an illegal len: error=1 for that start; stay in RUN.
- error is sticky until the next legal start or reset.
- Addresses written for a load of N words are BASE_ADDR + k*ADDR_STEP for k=0..N-1. No write is ever issued beyond N words.
- Words offered on s_valid outside LOAD are not consumed (s_ready=0).
- Never more than one instwen pulse per accepted word; instwen never high in IDLE, HOLD or RUN except the final-word pulse in the first HOLD cycle.

Test Plan:
1. Reset: hold reset=0 for 3 cycles with random inputs -> instwen=0, addwrite=0, instrdatain=0, cpu_reset=1, busy=0, done=0, error=0, s_ready=0.
2. Back-to-back load: start with len=3; stream 0x20080005, 0x20090007, 0x01095020 with s_valid continuously high -> instwen high 3 consecutive cycles at addwrite 0x0, 0x4, 0x8 with matching data; cpu_reset falls 2 cycles after the last instwen; done=1, busy=0.
3. Gapped valid: len=4, s_valid low 2 cycles between every word -> exactly 4 instwen pulses at 0x0, 0x4, 0x8, 0xC; addwrite and instrdatain stable between pulses; no extra writes.
4. Illegal length: start with len=0, then len=257 -> error=1, state stays IDLE, no instwen, s_ready=0. A following start with len=1 clears error.
5. Reset mid-load: len=5; drive reset=0 after 2 accepted words -> next cycle all outputs at reset values; after release, a fresh len=2 load writes from 0x0.
6. Reload from RUN: after scenario 2, start with len=1, data 0xDEADBEEF -> cpu_reset=1 and done=0 next cycle; single write at 0x0; cpu_reset deasserts 2 cycles after that write.
